// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: func3 codes, FSM states
// and access-width decode helpers.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Unknown codes fall back to a word access.
  function automatic logic [1:0] ld_size(logic [2:0] f3);
    logic [1:0] sz;
    unique case (f3)
      F3_LB, F3_LBU: sz = SZ_B;
      F3_LH, F3_LHU: sz = SZ_H;
      F3_LW:         sz = SZ_W;
      default:       sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [1:0] st_size(logic [2:0] f3);
    logic [1:0] sz;
    unique case (f3)
      F3_SB:   sz = SZ_B;
      F3_SH:   sz = SZ_H;
      F3_SW:   sz = SZ_W;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane generation for stores, alignment check, and
// load data extraction with sign/zero extension.
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        aligned,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [1:0]  sz;
  logic [1:0]  lsz;
  logic [31:0] sh;

  always_comb begin
    sz      = is_store ? st_size(f3) : ld_size(f3);
    be      = 4'b1111;
    wdata   = st_data;
    aligned = 1'b1;
    unique case (1'b1)
      (sz == SZ_B): begin
        be    = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
      end
      (sz == SZ_H): begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        aligned = ~off[0];
      end
      default: aligned = (off == 2'b00);
    endcase
  end

  always_comb begin
    lsz     = ld_size(ld_f3);
    sh      = rdata >> {ld_off, 3'b000};
    ld_data = rdata;
    unique case (1'b1)
      (lsz == SZ_B):
        ld_data = ld_f3[2] ? {24'h0, sh[7:0]}
                           : {{24{sh[7]}}, sh[7:0]};
      (lsz == SZ_H):
        ld_data = ld_f3[2] ? {16'h0, sh[15:0]}
                           : {{16{sh[15]}}, sh[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory accesses over req/ack, stalls
// while a bus access is outstanding and owns the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [2:0]  in_func3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic [31:0] data_forward_mem,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [31:0] fault_addr
);

  localparam int unsigned CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_be;
  logic [2:0]    cap_f3;
  logic [4:0]    cap_rd;
  logic          cap_rw;
  logic          cap_we;

  logic          mem_op;
  logic          in_bus;
  logic          to_hit;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          aligned;
  logic [31:0]   ld_data;

  load_store_align u_align (
    .is_store (in_mem_write),
    .f3       (in_func3),
    .off      (in_result[1:0]),
    .st_data  (in_store_data),
    .be       (be),
    .wdata    (wdata),
    .aligned  (aligned),
    .ld_f3    (cap_f3),
    .ld_off   (cap_addr[1:0]),
    .rdata    (dmem_rdata),
    .ld_data  (ld_data)
  );

  assign mem_op = in_valid & (in_mem_read | in_mem_write);
  assign in_bus = (state == ST_BUS);
  assign to_hit = TO_EN & in_bus & ~dmem_ack
                & (cnt == TO_LAST);

  // A timeout retires the op, so the stall must drop with it.
  assign stall_mem = in_bus ? (~dmem_ack & ~to_hit)
                            : (mem_op & aligned);

  assign data_forward_mem = in_result;
  assign dmem_req   = in_bus;
  assign dmem_we    = in_bus & cap_we;
  assign dmem_addr  = in_bus ? {cap_addr[31:2], 2'b00} : '0;
  assign dmem_be    = in_bus ? cap_be : '0;
  assign dmem_wdata = in_bus ? cap_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_be       <= '0;
      cap_f3       <= '0;
      cap_rd       <= '0;
      cap_rw       <= 1'b0;
      cap_we       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      fault_addr   <= '0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (state == ST_IDLE) begin
        if (mem_op && aligned) begin
          state        <= ST_BUS;
          cnt          <= '0;
          cap_addr     <= in_result;
          cap_wdata    <= wdata;
          cap_be       <= be;
          cap_f3       <= in_func3;
          cap_rd       <= in_rd;
          cap_rw       <= in_reg_write;
          cap_we       <= in_mem_write;
          wb_valid     <= 1'b0;
          wb_reg_write <= 1'b0;
        end else if (mem_op) begin
          wb_valid     <= 1'b1;
          wb_data      <= in_result;
          wb_rd        <= in_rd;
          wb_reg_write <= 1'b0;
          misalign_err <= 1'b1;
          fault_addr   <= in_result;
        end else begin
          wb_valid     <= in_valid;
          wb_data      <= in_result;
          wb_rd        <= in_rd;
          wb_reg_write <= in_valid & in_reg_write;
        end
      end else begin
        if (dmem_ack) begin
          state        <= ST_IDLE;
          wb_valid     <= 1'b1;
          wb_rd        <= cap_rd;
          wb_reg_write <= cap_rw & ~cap_we;
          wb_data      <= cap_we ? cap_addr : ld_data;
        end else if (to_hit) begin
          state        <= ST_IDLE;
          bus_err      <= 1'b1;
          fault_addr   <= cap_addr;
          wb_valid     <= 1'b1;
          wb_rd        <= cap_rd;
          wb_reg_write <= 1'b0;
          wb_data      <= '0;
        end else begin
          cnt      <= cnt + 1'b1;
          wb_valid <= 1'b0;
        end
      end
    end
  end

endmodule
